// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  // Counter must be able to hold DIVIDEND_W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module seq_divider_div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   r_in,
  input  logic                 d_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   r_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] dvsr_x;

  // The MSB of r_in is always 0 here, so shifting it out loses nothing.
  assign trial  = (r_in << 1) | {{DIVISOR_W{1'b0}}, d_bit};
  assign dvsr_x = {1'b0, divisor};
  assign q_bit  = (trial >= dvsr_x);
  assign r_out  = q_bit ? (trial - dvsr_x) : trial;

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);

  state_t                state;
  logic [DIVISOR_W:0]    r;
  logic [DIVISOR_W:0]    r_nxt;
  logic [DIVIDEND_W-1:0] shreg;
  logic [DIVISOR_W-1:0]  dvsr;
  logic [CNT_W-1:0]      cnt;
  logic                  q_bit;
  logic                  last;
  logic [DIVIDEND_W-1:0] shreg_nxt;

  seq_divider_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r_in    (r),
    .d_bit   (shreg[DIVIDEND_W-1]),
    .divisor (dvsr),
    .r_out   (r_nxt),
    .q_bit   (q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign shreg_nxt = {shreg[DIVIDEND_W-2:0], q_bit};
  assign last      = (cnt == CNT_W'(DIVIDEND_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      shreg       <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            dvsr  <= divisor;
            shreg <= dividend;
            r     <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          r     <= r_nxt;
          shreg <= shreg_nxt;
          cnt   <= cnt + 1'b1;
          if (last) begin
            quotient    <= shreg_nxt;
            remainder   <= r_nxt[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider; inputs driven and outputs sampled on falling edges.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int nvec = 0;
  int nerr = 0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Pulse start across exactly one rising edge (E0); returns at the falling edge after E0.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done; also tallies busy cycles and changes to held outputs.
  task automatic run_to_done(input logic [7:0] hq, input logic [3:0] hr,
                             output int lat, output int bcyc, output int hold_bad);
    lat = 0; bcyc = 0; hold_bad = 0;
    while (!done && lat < 30) begin
      if (busy) bcyc++;
      if (quotient !== hq || remainder !== hr) hold_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    nvec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_normal();
    int lat, bcyc, hb;
    start_op(8'd200, 4'd7);
    run_to_done(8'd0, 4'd0, lat, bcyc, hb);
    nvec++;
    if (lat !== 8) begin nerr++; $display("FAIL normal_latency: got %0d, want 8", lat); end
    nvec++;
    if (bcyc !== 8) begin nerr++; $display("FAIL normal_busy_cycles: got %0d, want 8", bcyc); end
    nvec++;
    if (hb !== 0) begin nerr++; $display("FAIL normal_hold: %0d output changes during CALC, want 0", hb); end
    nvec++;
    if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL normal_200_7: got q=%0d r=%0d dbz=%b busy=%b, want 28 4 0 0",
               quotient, remainder, div_by_zero, busy);
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b0) begin nerr++; $display("FAIL normal_done_width: done=%b one cycle later, want 0", done); end
  endtask

  task automatic test_edges();
    logic [7:0] a  [3] = '{8'd255, 8'd255, 8'd5};
    logic [3:0] b  [3] = '{4'd15, 4'd1, 4'd15};
    logic [7:0] eq [3] = '{8'd17, 8'd255, 8'd0};
    logic [3:0] er [3] = '{4'd0, 4'd0, 4'd5};
    int lat, bcyc, hb;
    for (int i = 0; i < 3; i++) begin
      start_op(a[i], b[i]);
      run_to_done(quotient, remainder, lat, bcyc, hb);
      nvec++;
      if (lat !== 8 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
        nerr++;
        $display("FAIL edge_%0d_%0d: got lat=%0d q=%0d r=%0d dbz=%b, want 8 %0d %0d 0",
                 a[i], b[i], lat, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcyc, hb;
    start_op(8'd8, 4'd0);
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL dbz_busy: got %b, want 0", busy); end
    run_to_done(quotient, remainder, lat, bcyc, hb);
    nvec++;
    if (lat !== 0) begin nerr++; $display("FAIL dbz_latency: got %0d, want 0", lat); end
    nvec++;
    if (quotient !== 8'hFF || remainder !== 4'd0 || div_by_zero !== 1'b1) begin
      nerr++;
      $display("FAIL dbz_result: got q=%h r=%0d dbz=%b, want ff 0 1", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
      nerr++;
      $display("FAIL dbz_after: got done=%b busy=%b dbz=%b, want 0 0 1", done, busy, div_by_zero);
    end
  endtask

  task automatic test_start_during_calc();
    int ndone = 0;
    logic [7:0] q = '0;
    logic [3:0] r = '0;
    start_op(8'd200, 4'd7);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin ndone++; q = quotient; r = remainder; end
      @(negedge clk);
    end
    nvec++;
    if (ndone !== 1) begin nerr++; $display("FAIL calc_start_done_count: got %0d, want 1", ndone); end
    nvec++;
    if (q !== 8'd28 || r !== 4'd4) begin
      nerr++;
      $display("FAIL calc_start_result: got q=%0d r=%0d, want 28 4", q, r);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcyc, hb;
    start_op(8'd200, 4'd7);
    run_to_done(quotient, remainder, lat, bcyc, hb);
    // Still in the DONE cycle: issue the next request right away.
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    nvec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_accept: got done=%b busy=%b, want 0 1", done, busy);
    end
    run_to_done(8'd28, 4'd4, lat, bcyc, hb);
    nvec++;
    if (lat !== 8) begin nerr++; $display("FAIL b2b_latency: got %0d, want 8", lat); end
    nvec++;
    if (hb !== 0) begin nerr++; $display("FAIL b2b_hold: first result changed %0d times, want 0", hb); end
    nvec++;
    if (quotient !== 8'd33 || remainder !== 4'd1) begin
      nerr++;
      $display("FAIL b2b_result: got q=%0d r=%0d, want 33 1", quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bcyc, hb;
    int ndone = 0;
    start_op(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      nerr++;
      $display("FAIL midreset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    nvec++;
    if (ndone !== 0) begin nerr++; $display("FAIL midreset_no_done: got %0d done pulses, want 0", ndone); end
    start_op(8'd50, 4'd6);
    run_to_done(8'd0, 4'd0, lat, bcyc, hb);
    nvec++;
    if (lat !== 8 || quotient !== 8'd8 || remainder !== 4'd2) begin
      nerr++;
      $display("FAIL midreset_50_6: got lat=%0d q=%0d r=%0d, want 8 8 2", lat, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_edges();
    test_div_zero();
    test_start_during_calc();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
